spi_register_bridge: RTL and testbench

SPI_REGISTER_BRIDGE -- requirements
Module: spi_register_bridge

---
 rtl/spi_register_bridge_pkg.sv | 18 +
 rtl/spi_register_bridge_sync_2ff.sv | 27 ++
 rtl/spi_register_bridge.sv | 136 +++++++++++++
 tb/tb_spi_register_bridge.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/spi_register_bridge_pkg.sv
// Shared definitions for the synth register file and its SPI bridge: frame
// layout, write command nibble, field widths and bridge FSM encodings.
package spi_register_bridge_pkg;

  localparam int CMD_W      = 4;
  localparam int REG_NUM_W  = 12;
  localparam int REG_VAL_W  = 24;
  localparam int BIT_CNT_W  = 6;
  localparam int WR_CNT_W   = 8;

  localparam int FRAME_BITS_DEFAULT = CMD_W + REG_NUM_W + REG_VAL_W;
  localparam logic [CMD_W-1:0] CMD_WRITE_DEFAULT = 4'hA;

  localparam logic [1:0] ST_WAIT_CS = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_SHIFT   = 2'd2;

endpackage

// File: rtl/spi_register_bridge_sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit, with a selectable reset
// value so an idle line can come out of reset at its inactive level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_register_bridge.sv
// SPI mode-0 slave that turns 40-bit frames (cmd | reg | value) into single
// cycle register-file writes, returning an accepted-write count on MISO.
//   state   | meaning
//   WAIT_CS | frame done or reset; wait for CS_N high before re-arming
//   IDLE    | armed, bit counter cleared, waiting for CS_N low
//   SHIFT   | shifting MOSI on SCLK rise, MISO on SCLK fall
module spi_register_bridge
  import spi_register_bridge_pkg::*;
#(
  parameter int               FRAME_BITS = FRAME_BITS_DEFAULT,
  parameter logic [CMD_W-1:0] CMD_WRITE  = CMD_WRITE_DEFAULT
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_SPI_SCLK,
  input  logic                 i_SPI_CS_N,
  input  logic                 i_SPI_MOSI,
  output logic                 o_SPI_MISO,
  output logic [REG_NUM_W-1:0] o_RegisterNumber,
  output logic [REG_VAL_W-1:0] o_RegisterValue,
  output logic                 o_RegisterWriteEnable
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  logic sclk_s, cs_n_s, mosi_s;
  logic sclk_prev_q;
  logic sclk_rise, sclk_fall;

  logic [1:0]            state_q, state_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d, frame_next;
  logic [REG_NUM_W-1:0]  reg_num_q, reg_num_d;
  logic [REG_VAL_W-1:0]  reg_val_q, reg_val_d;
  logic                  wr_en_q, wr_en_d;
  logic [WR_CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [WR_CNT_W-1:0]   miso_sr_q, miso_sr_d;
  logic                  miso_q, miso_d;

  sync_2ff #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i(i_Clock), .rst_i(i_Reset), .d_i(i_SPI_SCLK), .q_o(sclk_s)
  );
  sync_2ff #(.RESET_VAL(1'b1)) u_sync_cs_n (
    .clk_i(i_Clock), .rst_i(i_Reset), .d_i(i_SPI_CS_N), .q_o(cs_n_s)
  );
  sync_2ff #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i(i_Clock), .rst_i(i_Reset), .d_i(i_SPI_MOSI), .q_o(mosi_s)
  );

  assign sclk_rise  = sclk_s & ~sclk_prev_q;
  assign sclk_fall  = ~sclk_s & sclk_prev_q;
  assign frame_next = (shift_q << 1) | {{(FRAME_BITS-1){1'b0}}, mosi_s};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    reg_num_d = reg_num_q;
    reg_val_d = reg_val_q;
    wr_en_d   = 1'b0;
    wr_cnt_d  = wr_cnt_q;
    miso_sr_d = miso_sr_q;
    miso_d    = miso_q;
    case (state_q)
      ST_WAIT_CS: begin
        miso_d = 1'b0;
        if (cs_n_s) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        bit_cnt_d = '0;
        miso_d    = 1'b0;
        if (!cs_n_s) begin
          // Snapshot the count so MISO is stable for the whole frame.
          state_d   = ST_SHIFT;
          miso_d    = wr_cnt_q[WR_CNT_W-1];
          miso_sr_d = {wr_cnt_q[WR_CNT_W-2:0], 1'b0};
        end
      end
      ST_SHIFT: begin
        if (cs_n_s) begin
          state_d = ST_IDLE;
          miso_d  = 1'b0;
        end else if (sclk_rise) begin
          shift_d   = frame_next;
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_WAIT_CS;
            miso_d  = 1'b0;
            if (frame_next[FRAME_BITS-1 -: CMD_W] == CMD_WRITE) begin
              reg_num_d = frame_next[REG_VAL_W +: REG_NUM_W];
              reg_val_d = frame_next[REG_VAL_W-1:0];
              wr_en_d   = 1'b1;
              wr_cnt_d  = wr_cnt_q + WR_CNT_W'(1);
            end
          end
        end else if (sclk_fall) begin
          miso_d    = miso_sr_q[WR_CNT_W-1];
          miso_sr_d = miso_sr_q << 1;
        end
      end
      default: state_d = ST_WAIT_CS;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      sclk_prev_q <= 1'b0;
      state_q     <= ST_WAIT_CS;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      reg_num_q   <= '0;
      reg_val_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_cnt_q    <= '0;
      miso_sr_q   <= '0;
      miso_q      <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      reg_num_q   <= reg_num_d;
      reg_val_q   <= reg_val_d;
      wr_en_q     <= wr_en_d;
      wr_cnt_q    <= wr_cnt_d;
      miso_sr_q   <= miso_sr_d;
      miso_q      <= miso_d;
    end
  end

  assign o_SPI_MISO            = miso_q;
  assign o_RegisterNumber      = reg_num_q;
  assign o_RegisterValue       = reg_val_q;
  assign o_RegisterWriteEnable = wr_en_q;

endmodule

// File: tb/tb_spi_register_bridge.sv
// Directed bench for spi_register_bridge: frames driven bit by bit, strobe
// timing, held outputs, aborts, over-clocking, mid-frame reset, count wrap.
module tb_spi_register_bridge;

  logic        clk;
  logic        rst;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic [11:0] reg_num;
  logic [23:0] reg_val;
  logic        wr_en;

  int checks;
  int errors;
  int strobe_cnt;
  int base_cnt;
  logic [39:0] mb;

  spi_register_bridge dut (
    .i_Clock              (clk),
    .i_Reset              (rst),
    .i_SPI_SCLK           (sclk),
    .i_SPI_CS_N           (cs_n),
    .i_SPI_MOSI           (mosi),
    .o_SPI_MISO           (miso),
    .o_RegisterNumber     (reg_num),
    .o_RegisterValue      (reg_val),
    .o_RegisterWriteEnable(wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && wr_en) strobe_cnt <= strobe_cnt + 1;
  end

  initial begin
    #1500000;
    $display("FAIL timeout: run did not reach summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one CS_N window; nbits SCLK pulses with the given half period.
  // At the 40th rise, checks the strobe cycle by cycle from edge N.
  task automatic frame(input logic [39:0] data, input int nbits, input int half,
                       input bit exp_wr, input int reset_at,
                       output logic [39:0] miso_bits);
    miso_bits = '0;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (half) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == reset_at) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_wr_en", {39'b0, wr_en}, 40'h0);
        check("rst_num", {28'b0, reg_num}, 40'h0);
        check("rst_val", {16'b0, reg_val}, 40'h0);
        check("rst_miso", {39'b0, miso}, 40'h0);
        rst = 1'b0;
      end
      mosi = (i < 40) ? data[39-i] : 1'b1;
      repeat (half) @(negedge clk);
      if (i < 40) miso_bits[39-i] = miso;
      sclk = 1'b1;
      if (i == 39) begin
        @(posedge clk); #1;
        check("strobe_N", {39'b0, wr_en}, 40'h0);
        @(posedge clk); #1;
        check("strobe_N1", {39'b0, wr_en}, 40'h0);
        @(posedge clk); #1;
        check("strobe_N2", {39'b0, wr_en}, {39'b0, exp_wr});
        if (exp_wr) begin
          check("strobe_num", {28'b0, reg_num}, {28'b0, data[35:24]});
          check("strobe_val", {16'b0, reg_val}, {16'b0, data[23:0]});
        end
        @(posedge clk); #1;
        check("strobe_N3", {39'b0, wr_en}, 40'h0);
        @(negedge clk);
      end else begin
        repeat (half) @(negedge clk);
      end
      sclk = 1'b0;
    end
    repeat (half) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    strobe_cnt = 0;
    rst  = 1'b1;
    sclk = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_num", {28'b0, reg_num}, 40'h0);
    check("reset_val", {16'b0, reg_val}, 40'h0);
    check("reset_wr_en", {39'b0, wr_en}, 40'h0);
    check("reset_miso", {39'b0, miso}, 40'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Basic write, SCLK period 8 clocks; count was 0.
    base_cnt = strobe_cnt;
    frame(40'hA_123_ABCDEF, 40, 4, 1'b1, -1, mb);
    check("w1_strobes", 40'(strobe_cnt - base_cnt), 40'd1);
    check("w1_num", {28'b0, reg_num}, 40'h123);
    check("w1_val", {16'b0, reg_val}, 40'hABCDEF);
    check("w1_miso", mb, 40'h00_00000000);

    // Non-matching command: no strobe, outputs hold; count still 1.
    base_cnt = strobe_cnt;
    frame(40'h5_123_ABCDEF, 40, 4, 1'b0, -1, mb);
    check("nm_strobes", 40'(strobe_cnt - base_cnt), 40'd0);
    check("nm_num", {28'b0, reg_num}, 40'h123);
    check("nm_val", {16'b0, reg_val}, 40'hABCDEF);
    check("nm_miso", mb, 40'h01_00000000);

    // Abort after 20 bits, then a full frame.
    base_cnt = strobe_cnt;
    frame(40'hA_FFF_FFFFFF, 20, 4, 1'b0, -1, mb);
    check("abort_strobes", 40'(strobe_cnt - base_cnt), 40'd0);
    check("abort_num", {28'b0, reg_num}, 40'h123);
    frame(40'hA_001_000001, 40, 4, 1'b1, -1, mb);
    check("ab2_strobes", 40'(strobe_cnt - base_cnt), 40'd1);
    check("ab2_num", {28'b0, reg_num}, 40'h001);
    check("ab2_val", {16'b0, reg_val}, 40'h000001);
    check("ab2_miso", mb, 40'h01_00000000);

    // 44 pulses in one window: extra edges ignored.
    base_cnt = strobe_cnt;
    frame(40'hA_0FF_123456, 44, 4, 1'b1, -1, mb);
    check("x44_strobes", 40'(strobe_cnt - base_cnt), 40'd1);
    check("x44_num", {28'b0, reg_num}, 40'h0FF);
    check("x44_val", {16'b0, reg_val}, 40'h123456);
    check("x44_miso", mb, 40'h02_00000000);

    // Reset at bit 30 with CS_N low; remaining bits must not write.
    base_cnt = strobe_cnt;
    frame(40'hA_777_777777, 40, 4, 1'b0, 30, mb);
    check("rmid_strobes", 40'(strobe_cnt - base_cnt), 40'd0);
    check("rmid_num", {28'b0, reg_num}, 40'h0);
    check("rmid_val", {16'b0, reg_val}, 40'h0);
    frame(40'hA_456_654321, 40, 4, 1'b1, -1, mb);
    check("rpost_strobes", 40'(strobe_cnt - base_cnt), 40'd1);
    check("rpost_num", {28'b0, reg_num}, 40'h456);
    check("rpost_val", {16'b0, reg_val}, 40'h654321);
    check("rpost_miso", mb, 40'h00_00000000);

    // Count is 1; 255 more writes at minimum SCLK phases wrap it to 0.
    base_cnt = strobe_cnt;
    for (int k = 0; k < 255; k++) begin
      frame({4'hA, 12'(k), 24'(k)}, 40, 3, 1'b1, -1, mb);
      if (k == 254) check("pre_wrap_miso", mb, 40'hFF_00000000);
    end
    check("bulk_strobes", 40'(strobe_cnt - base_cnt), 40'd255);
    check("bulk_num", {28'b0, reg_num}, 40'h0FE);
    check("bulk_val", {16'b0, reg_val}, 40'h0000FE);
    frame(40'hA_ABC_000000, 40, 4, 1'b1, -1, mb);
    check("wrap_miso", mb, 40'h00_00000000);
    check("wrap_num", {28'b0, reg_num}, 40'hABC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
